// File: rtl/ovl_delta_stim.sv
// Stimulus source for a bounded-delta checker: emits WIDTH-bit samples whose
// consecutive modular deltas sit inside [min,max], with optional flagged violations.
module ovl_delta_stim #(
    parameter int          WIDTH = 12,
    parameter int          DW    = 3,
    parameter int          CNTW  = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    min,
    input  logic [DW-1:0]    max,
    input  logic             inject,
    input  logic [CNTW-1:0]  len,
    input  logic             ready,
    output logic [WIDTH-1:0] test_expr,
    output logic             valid,
    output logic             expect_fire,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             fire_q, fire_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [DW-1:0]    min_q, min_d;
    logic [DW-1:0]    max_q, max_d;
    logic             inject_q, inject_d;
    logic [CNTW-1:0]  len_q, len_d;

    logic [15:0]      lfsr_adv;
    logic [CNTW-1:0]  cnt_inc;
    logic [DW-1:0]    r_val;
    logic [DW-1:0]    span;
    logic             violate;
    logic [DW:0]      step;
    logic [WIDTH-1:0] next_sample;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cnt_inc  = cnt_q + CNTW'(1);
    assign r_val    = lfsr_adv[DW-1:0];
    assign span     = max_q - min_q;
    assign violate  = inject_q && (cnt_inc[1:0] == 2'b11);

    always_comb begin
        step = {1'b0, min_q};
        if (violate) begin
            step = {1'b0, max_q} + (DW+1)'(1);
        end else if (r_val <= span) begin
            step = {1'b0, min_q} + {1'b0, r_val};
        end
    end

    // Modular wrap is deliberate: the checker compares differences mod 2^WIDTH.
    assign next_sample = lfsr_adv[15] ? (sample_q - WIDTH'(step)) : (sample_q + WIDTH'(step));

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        fire_d    = fire_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        min_d     = min_q;
        max_d     = max_q;
        inject_d  = inject_q;
        len_d     = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    min_d     = min;
                    max_d     = max;
                    inject_d  = inject;
                    len_d     = len;
                    lfsr_d    = SEED;
                    cnt_d     = '0;
                    cfg_err_d = 1'b0;
                    fire_d    = 1'b0;
                    busy_d    = 1'b1;
                    if (min > max) begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else if (len == '0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        sample_d = WIDTH'(SEED);
                        valid_d  = 1'b1;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (valid_q && ready) begin
                    cnt_d  = cnt_inc;
                    lfsr_d = lfsr_adv;
                    if (cnt_inc == len_q) begin
                        valid_d = 1'b0;
                        fire_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        sample_d = next_sample;
                        fire_d   = violate;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            fire_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            min_q     <= '0;
            max_q     <= '0;
            inject_q  <= 1'b0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            fire_q    <= fire_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            min_q     <= min_d;
            max_q     <= max_d;
            inject_q  <= inject_d;
            len_q     <= len_d;
        end
    end

    assign test_expr   = sample_q;
    assign valid       = valid_q;
    assign expect_fire = fire_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_ovl_delta_stim.sv
// Scoreboard bench for ovl_delta_stim: hand-derived sample sequences are queued at
// stimulus time and a negedge monitor pops them on every accepted sample.
module tb_ovl_delta_stim;

    localparam int WIDTH = 12;
    localparam int DW    = 3;
    localparam int CNTW  = 8;
    localparam int NW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [DW-1:0]    min_v = '0;
    logic [DW-1:0]    max_v = '0;
    logic             inject = 1'b0;
    logic [CNTW-1:0]  len = '0;
    logic             ready = 1'b1;
    logic [WIDTH-1:0] test_expr;
    logic             valid, expect_fire, busy, done, cfg_err;

    logic             n_start = 1'b0;
    logic [DW-1:0]    n_min = 3'd7;
    logic [DW-1:0]    n_max = 3'd7;
    logic [CNTW-1:0]  n_len = 8'd8;
    logic [NW-1:0]    n_expr;
    logic             n_valid, n_fire, n_busy, n_done, n_cfg_err;

    typedef struct {
        logic [WIDTH-1:0] value;
        logic             fire;
    } exp_t;

    exp_t wq[$];
    exp_t nq[$];
    int   checks = 0;
    int   errors = 0;
    logic toggle_mode = 1'b0;
    int   phase = 0;

    // First samples of each directed run, derived by hand from the LFSR stepping
    // ACE1 -> E270 -> 7138 -> 389C -> 1C4E -> 0E27 -> B313 -> ED89 -> C2C4 -> 6162 -> 30B1 -> AC58.
    logic [WIDTH-1:0] seq_a [0:7]  = '{12'hCE1, 12'hCE0, 12'hCE1, 12'hCE2, 12'hCE3, 12'hCE4, 12'hCE3, 12'hCE1};
    logic [WIDTH-1:0] seq_b [0:11] = '{12'hCE1, 12'hCDF, 12'hCE1, 12'hCE4, 12'hCE6, 12'hCE8,
                                       12'hCE6, 12'hCE3, 12'hCE1, 12'hCE3, 12'hCE5, 12'hCE2};
    logic [NW-1:0]    seq_n [0:7]  = '{5'd1, 5'd26, 5'd1, 5'd8, 5'd15, 5'd22, 5'd15, 5'd8};

    ovl_delta_stim #(.WIDTH(WIDTH), .DW(DW), .CNTW(CNTW), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .min(min_v), .max(max_v),
        .inject(inject), .len(len), .ready(ready), .test_expr(test_expr),
        .valid(valid), .expect_fire(expect_fire), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    ovl_delta_stim #(.WIDTH(NW), .DW(DW), .CNTW(CNTW), .SEED(16'hACE1)) dut_narrow (
        .clk(clk), .rst(rst), .start(n_start), .min(n_min), .max(n_max),
        .inject(1'b0), .len(n_len), .ready(1'b1), .test_expr(n_expr),
        .valid(n_valid), .expect_fire(n_fire), .busy(n_busy), .done(n_done),
        .cfg_err(n_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Ready pattern 1,0,0,1 when toggling, otherwise held high.
    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_mode) begin
            ready = (phase % 4 == 0) || (phase % 4 == 3);
            phase++;
        end else begin
            ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted sample and checks stall stability.
    initial begin
        logic             stalled;
        logic [WIDTH-1:0] held_value;
        logic             held_fire;
        exp_t             e;
        stalled = 1'b0;
        held_value = '0;
        held_fire = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled && valid) begin
                check_output("hold_value", 32'(test_expr), 32'(held_value));
                check_output("hold_fire", 32'(expect_fire), 32'(held_fire));
            end
            stalled = 1'b0;
            if (valid && ready) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_sample: got %0h, expected no sample", test_expr);
                end else begin
                    e = wq.pop_front();
                    check_output("sample_value", 32'(test_expr), 32'(e.value));
                    check_output("sample_fire", 32'(expect_fire), 32'(e.fire));
                end
            end else if (valid) begin
                stalled    = 1'b1;
                held_value = test_expr;
                held_fire  = expect_fire;
            end
            if (n_valid) begin
                if (nq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL narrow_unexpected: got %0h, expected no sample", n_expr);
                end else begin
                    e = nq.pop_front();
                    check_output("narrow_value", 32'(n_expr), 32'(e.value));
                    check_output("narrow_fire", 32'(n_fire), 32'(e.fire));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [DW-1:0] mn, input logic [DW-1:0] mx,
                                  input logic inj, input logic [CNTW-1:0] ln);
        @(posedge clk);
        #1;
        min_v  = mn;
        max_v  = mx;
        inject = inj;
        len    = ln;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_done"}, 32'(done), 32'd1);
        check_output({name, "_busy_in_done"}, 32'(busy), 32'd1);
        check_output({name, "_valid_in_done"}, 32'(valid), 32'd0);
        check_output({name, "_drained"}, 32'(wq.size()), 32'd0);
        if (exp_cycles >= 0) begin
            check_output({name, "_done_latency"}, 32'(n), 32'(exp_cycles));
        end
        @(negedge clk);
        check_output({name, "_done_pulse"}, 32'(done), 32'd0);
        check_output({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic push_seq_a();
        for (int i = 0; i < 8; i++) wq.push_back('{value: seq_a[i], fire: 1'b0});
    endtask

    task automatic push_seq_b();
        for (int i = 0; i < 12; i++) wq.push_back('{value: seq_b[i], fire: (i % 4 == 3)});
    endtask

    initial begin
        int n;
        #2;
        check_output("reset_test_expr", 32'(test_expr), 32'd0);
        check_output("reset_valid", 32'(valid), 32'd0);
        check_output("reset_fire", 32'(expect_fire), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_cfg_err", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] window 1..3, len 8, continuous ready");
        push_seq_a();
        apply_stimulus(3'd1, 3'd3, 1'b0, 8'd8);
        wait_done("run_a", 40, 8);

        $display("[TB] window 2..2, len 12, inject");
        push_seq_b();
        apply_stimulus(3'd2, 3'd2, 1'b1, 8'd12);
        wait_done("run_b", 40, 12);

        $display("[TB] window 2..2, len 12, inject, ready toggling");
        push_seq_b();
        phase = 0;
        toggle_mode = 1'b1;
        apply_stimulus(3'd2, 3'd2, 1'b1, 8'd12);
        wait_done("run_b_stall", 200, -1);
        toggle_mode = 1'b0;

        $display("[TB] min > max rejected");
        apply_stimulus(3'd5, 3'd3, 1'b0, 8'd4);
        #1;
        check_output("cfg_err_set", 32'(cfg_err), 32'd1);
        wait_done("cfg_reject", 10, 0);
        check_output("cfg_err_sticky", 32'(cfg_err), 32'd1);

        $display("[TB] zero window repeats the seed");
        for (int i = 0; i < 4; i++) wq.push_back('{value: 12'hCE1, fire: 1'b0});
        apply_stimulus(3'd0, 3'd0, 1'b0, 8'd4);
        check_output("cfg_err_cleared", 32'(cfg_err), 32'd0);
        wait_done("zero_window", 20, 4);

        $display("[TB] len 0");
        apply_stimulus(3'd1, 3'd3, 1'b0, 8'd0);
        wait_done("len_zero", 10, 0);

        $display("[TB] narrow instance wrap-around");
        for (int i = 0; i < 8; i++) nq.push_back('{value: WIDTH'(seq_n[i]), fire: 1'b0});
        @(posedge clk);
        #1;
        n_start = 1'b1;
        @(posedge clk);
        #1;
        n_start = 1'b0;
        n = 0;
        while (!n_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output("narrow_done", 32'(n_done), 32'd1);
        check_output("narrow_drained", 32'(nq.size()), 32'd0);

        $display("[TB] reset mid-run");
        push_seq_a();
        apply_stimulus(3'd1, 3'd3, 1'b0, 8'd8);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("midrst_test_expr", 32'(test_expr), 32'd0);
        check_output("midrst_valid", 32'(valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_done", 32'(done), 32'd0);
        check_output("midrst_popped", 32'(wq.size()), 32'd5);
        wq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_no_done", 32'(done), 32'd0);
        push_seq_a();
        apply_stimulus(3'd1, 3'd3, 1'b0, 8'd8);
        wait_done("restart", 40, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
